// File: rtl/avmm_cmd_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM master among NUM_REQ command sources.
// One transaction in flight; read data or a timeout error goes back to the granted source.
module avmm_cmd_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                            clock,
  input  logic                            reset_n,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_address,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
  input  logic [NUM_REQ-1:0]              req_read_writen,
  output logic [NUM_REQ-1:0]              rsp_valid,
  output logic [DATA_WIDTH-1:0]           rsp_readdata,
  output logic                            rsp_error,
  output logic [ADDR_WIDTH-1:0]           avm_address,
  output logic                            avm_read,
  output logic                            avm_write,
  output logic [DATA_WIDTH-1:0]           avm_writedata,
  input  logic                            avm_waitrequest,
  input  logic [DATA_WIDTH-1:0]           avm_readdata,
  input  logic                            avm_readdatavalid,
  output logic                            busy,
  output logic [$clog2(NUM_REQ)-1:0]      grant_id
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_RD, S_RESP} state_t;

  state_t                  r_state;
  logic [GW-1:0]           r_last;
  logic [GW-1:0]           r_gid;
  logic [TW-1:0]           r_timer;
  logic                    r_is_rd;
  logic                    r_err;
  logic [DATA_WIDTH-1:0]   r_rdata;
  logic [NUM_REQ-1:0]      r_req_ready;
  logic [NUM_REQ-1:0]      r_rsp_valid;
  logic [DATA_WIDTH-1:0]   r_rsp_rdata;
  logic                    r_rsp_err;
  logic [ADDR_WIDTH-1:0]   r_avm_addr;
  logic [DATA_WIDTH-1:0]   r_avm_wdata;
  logic                    r_avm_read;
  logic                    r_avm_write;
  logic                    r_busy;

  logic [GW-1:0]           w_pick;
  logic                    w_any;
  logic [TW-1:0]           w_tnext;
  logic                    w_expire;

  // First pending requester strictly after the last completed grant, wrapping.
  function automatic logic [GW-1:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                            input logic [GW-1:0] last);
    logic [GW:0] j;
    logic        found;
    rr_pick = '0;
    found   = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      j = {1'b0, last} + (GW+1)'(k);
      if (j >= (GW+1)'(NUM_REQ)) j = j - (GW+1)'(NUM_REQ);
      if (!found && v[j[GW-1:0]]) begin
        found   = 1'b1;
        rr_pick = j[GW-1:0];
      end
    end
  endfunction

  assign w_any    = |req_valid;
  assign w_pick   = rr_pick(req_valid, r_last);
  assign w_tnext  = (r_timer == '1) ? r_timer : r_timer + 1'b1;
  // Completion in the expiry cycle is checked first, so it wins over the abort.
  assign w_expire = (TIMEOUT_CYCLES != 0) && (w_tnext >= TMAX);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_last      <= GW'(NUM_REQ - 1);
      r_gid       <= '0;
      r_timer     <= '0;
      r_is_rd     <= 1'b0;
      r_err       <= 1'b0;
      r_rdata     <= '0;
      r_req_ready <= '0;
      r_rsp_valid <= '0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_avm_addr  <= '0;
      r_avm_wdata <= '0;
      r_avm_read  <= 1'b0;
      r_avm_write <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_req_ready <= '0;
      r_rsp_valid <= '0;
      case (r_state)
        S_IDLE: if (w_any) begin
          r_gid               <= w_pick;
          r_req_ready[w_pick] <= 1'b1;
          r_avm_addr          <= req_address[w_pick*ADDR_WIDTH +: ADDR_WIDTH];
          r_avm_wdata         <= req_data[w_pick*DATA_WIDTH +: DATA_WIDTH];
          r_is_rd             <= req_read_writen[w_pick];
          r_avm_read          <= req_read_writen[w_pick];
          r_avm_write         <= !req_read_writen[w_pick];
          r_timer             <= '0;
          r_err               <= 1'b0;
          r_rdata             <= '0;
          r_busy              <= 1'b1;
          r_state             <= S_ISSUE;
        end
        S_ISSUE: begin
          r_timer <= w_tnext;
          if (!avm_waitrequest) begin
            r_avm_read  <= 1'b0;
            r_avm_write <= 1'b0;
            if (!r_is_rd) begin
              r_state <= S_RESP;
            end else if (avm_readdatavalid) begin
              r_rdata <= avm_readdata;
              r_state <= S_RESP;
            end else begin
              r_state <= S_WAIT_RD;
            end
          end else if (w_expire) begin
            r_avm_read  <= 1'b0;
            r_avm_write <= 1'b0;
            r_rdata     <= '0;
            r_err       <= 1'b1;
            r_state     <= S_RESP;
          end
        end
        S_WAIT_RD: begin
          r_timer <= w_tnext;
          if (avm_readdatavalid) begin
            r_rdata <= avm_readdata;
            r_state <= S_RESP;
          end else if (w_expire) begin
            r_rdata <= '0;
            r_err   <= 1'b1;
            r_state <= S_RESP;
          end
        end
        S_RESP: begin
          r_rsp_valid[r_gid] <= 1'b1;
          r_rsp_rdata        <= r_rdata;
          r_rsp_err          <= r_err;
          r_last             <= r_gid;
          r_busy             <= 1'b0;
          r_state            <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready     = r_req_ready;
  assign rsp_valid     = r_rsp_valid;
  assign rsp_readdata  = r_rsp_rdata;
  assign rsp_error     = r_rsp_err;
  assign avm_address   = r_avm_addr;
  assign avm_read      = r_avm_read;
  assign avm_write     = r_avm_write;
  assign avm_writedata = r_avm_wdata;
  assign busy          = r_busy;
  assign grant_id      = r_gid;

endmodule

// File: tb/tb_avmm_cmd_arbiter.sv
// Directed bench for avmm_cmd_arbiter: writes, stalled/zero-latency reads, round-robin,
// timeout abort and mid-transaction reset; outputs sampled on the falling edge.
module tb_avmm_cmd_arbiter;
  localparam int NR = 4;
  localparam int AW = 8;
  localparam int DW = 32;

  logic              clock = 1'b0;
  logic              reset_n;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR*AW-1:0]  req_address;
  logic [NR*DW-1:0]  req_data;
  logic [NR-1:0]     req_read_writen;
  logic [NR-1:0]     rsp_valid;
  logic [DW-1:0]     rsp_readdata;
  logic              rsp_error;
  logic [AW-1:0]     avm_address;
  logic              avm_read;
  logic              avm_write;
  logic [DW-1:0]     avm_writedata;
  logic              avm_waitrequest;
  logic [DW-1:0]     avm_readdata;
  logic              avm_readdatavalid;
  logic              busy;
  logic [1:0]        grant_id;

  int n_chk  = 0;
  int n_fail = 0;

  avmm_cmd_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(8)) dut (
    .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_address(req_address), .req_data(req_data), .req_read_writen(req_read_writen),
    .rsp_valid(rsp_valid), .rsp_readdata(rsp_readdata), .rsp_error(rsp_error),
    .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_waitrequest(avm_waitrequest),
    .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid),
    .busy(busy), .grant_id(grant_id));

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clock);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"},  64'(req_ready), 64'h0);
    chk({tag, "_rspv"},   64'(rsp_valid), 64'h0);
    chk({tag, "_rdata"},  64'(rsp_readdata), 64'h0);
    chk({tag, "_err"},    64'(rsp_error), 64'h0);
    chk({tag, "_rd_wr"},  64'({avm_read, avm_write}), 64'h0);
    chk({tag, "_addr"},   64'(avm_address), 64'h0);
    chk({tag, "_wdata"},  64'(avm_writedata), 64'h0);
    chk({tag, "_busy"},   64'(busy), 64'h0);
    chk({tag, "_gid"},    64'(grant_id), 64'h0);
  endtask

  initial begin
    int n_gr;
    logic [1:0] exp_order [5];
    exp_order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    reset_n = 1'b0; req_valid = '0; req_address = '0; req_data = '0; req_read_writen = '0;
    avm_waitrequest = 1'b0; avm_readdata = '0; avm_readdatavalid = 1'b0;
    cyc(); cyc();
    chk_all_zero("reset");
    reset_n = 1'b1;

    // 1: single write from requester 0
    req_valid = 4'b0001; req_address[0*AW +: AW] = 8'h00; req_data[0*DW +: DW] = 32'h1;
    req_read_writen[0] = 1'b0;
    cyc();
    chk("wr_ready", 64'(req_ready), 64'h1);
    chk("wr_write", 64'({avm_read, avm_write}), 64'h1);
    chk("wr_wdata", 64'(avm_writedata), 64'h1);
    chk("wr_gid",   64'(grant_id), 64'h0);
    chk("wr_busy",  64'(busy), 64'h1);
    req_valid = '0;
    cyc();
    chk("wr_drop",  64'({req_ready, avm_write, rsp_valid}), 64'h0);
    cyc();
    chk("wr_rspv",  64'(rsp_valid), 64'h1);
    chk("wr_err",   64'(rsp_error), 64'h0);
    chk("wr_rdata", 64'(rsp_readdata), 64'h0);
    chk("wr_idle",  64'(busy), 64'h0);
    cyc();
    chk("wr_pulse", 64'(rsp_valid), 64'h0);

    // 2: stalled read from requester 1, data two cycles after accept
    req_valid = 4'b0010; req_address[1*AW +: AW] = 8'h12; req_read_writen[1] = 1'b1;
    avm_waitrequest = 1'b1;
    cyc();
    chk("rd_ready", 64'(req_ready), 64'h2);
    chk("rd_gid",   64'(grant_id), 64'h1);
    req_valid = '0;
    for (int i = 0; i < 3; i++) begin
      chk("rd_stall_addr", 64'(avm_address), 64'h12);
      chk("rd_stall_read", 64'({avm_read, avm_write}), 64'h2);
      cyc();
    end
    chk("rd_stall_end", 64'(avm_read), 64'h1);
    avm_waitrequest = 1'b0;
    cyc();
    chk("rd_accepted", 64'(avm_read), 64'h0);
    avm_waitrequest = 1'b1;
    cyc();
    avm_readdatavalid = 1'b1; avm_readdata = 32'hA5A5_0001;
    cyc();
    avm_readdatavalid = 1'b0; avm_readdata = '0; avm_waitrequest = 1'b0;
    chk("rd_in_resp", 64'(rsp_valid), 64'h0);
    cyc();
    chk("rd_rspv",  64'(rsp_valid), 64'h2);
    chk("rd_rdata", 64'(rsp_readdata), 64'hA5A5_0001);
    chk("rd_err",   64'(rsp_error), 64'h0);

    // 5: zero-latency read from requester 2
    req_valid = 4'b0100; req_address[2*AW +: AW] = 8'h22; req_read_writen[2] = 1'b1;
    cyc();
    chk("zl_ready", 64'(req_ready), 64'h4);
    chk("zl_read",  64'(avm_read), 64'h1);
    chk("zl_addr",  64'(avm_address), 64'h22);
    req_valid = '0; avm_readdatavalid = 1'b1; avm_readdata = 32'h5;
    cyc();
    avm_readdatavalid = 1'b0; avm_readdata = '0;
    chk("zl_drop",  64'({avm_read, rsp_valid}), 64'h0);
    cyc();
    chk("zl_rspv",  64'(rsp_valid), 64'h4);
    chk("zl_rdata", 64'(rsp_readdata), 64'h5);

    // 4: read from requester 3 that never completes -> abort after 8 cycles
    req_valid = 4'b1000; req_address[3*AW +: AW] = 8'h33; req_read_writen[3] = 1'b1;
    avm_waitrequest = 1'b1;
    cyc();
    chk("to_ready", 64'(req_ready), 64'h8);
    req_valid = '0;
    for (int i = 1; i < 8; i++) begin
      cyc();
      chk("to_read_held", 64'(avm_read), 64'h1);
    end
    cyc();
    chk("to_read_drop", 64'(avm_read), 64'h0);
    chk("to_busy",      64'({busy, rsp_valid}), 64'h10);
    cyc();
    avm_waitrequest = 1'b0;
    chk("to_rspv",  64'(rsp_valid), 64'h8);
    chk("to_err",   64'(rsp_error), 64'h1);
    chk("to_rdata", 64'(rsp_readdata), 64'h0);
    avm_readdatavalid = 1'b1; avm_readdata = 32'hDEAD_BEEF;
    cyc();
    avm_readdatavalid = 1'b0; avm_readdata = '0;
    cyc();
    chk("late_rdv_rspv",  64'({rsp_valid, busy}), 64'h0);
    chk("late_rdv_rdata", 64'(rsp_readdata), 64'h0);
    chk("late_rdv_err",   64'(rsp_error), 64'h1);

    // 3: all four requesters pending continuously -> 0,1,2,3,0
    req_valid = 4'b1111; req_read_writen = '0;
    n_gr = 0;
    for (int c = 0; c < 30 && n_gr < 5; c++) begin
      cyc();
      if (req_ready != '0) begin
        chk("rr_onehot", 64'($onehot(req_ready)), 64'h1);
        chk("rr_order",  64'(req_ready), 64'(4'b0001 << exp_order[n_gr]));
        chk("rr_gid",    64'(grant_id), 64'(exp_order[n_gr]));
        n_gr++;
      end
    end
    chk("rr_count", 64'(n_gr), 64'd5);
    req_valid = '0;
    for (int c = 0; c < 4; c++) cyc();
    chk("rr_drained", 64'(busy), 64'h0);

    // 6: reset while waiting for read data from requester 1
    req_valid = 4'b0010; req_read_writen[1] = 1'b1;
    cyc();
    chk("rst_ready", 64'(req_ready), 64'h2);
    req_valid = '0;
    cyc();
    chk("rst_wait", 64'({busy, avm_read}), 64'h2);
    #2 reset_n = 1'b0;
    #1 chk_all_zero("async_rst");
    cyc();
    reset_n = 1'b1;
    avm_readdatavalid = 1'b1; avm_readdata = 32'h1234_5678;
    cyc();
    avm_readdatavalid = 1'b0; avm_readdata = '0;
    cyc();
    chk("rst_no_fwd", 64'({rsp_valid, busy}), 64'h0);
    req_valid = 4'b0011; req_read_writen = '0;
    cyc();
    chk("rst_first_grant", 64'(req_ready), 64'h1);
    req_valid = '0;
    for (int c = 0; c < 4; c++) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
